// File: rtl/prefix_accumulator_pkg.sv
// Shared prefix definitions: segment index codes, FSM state codes and the
// merged prefix record handed to the opcode decoder.
package prefix_accumulator_pkg;

    localparam int unsigned MAX_PREFIX_DEFAULT = 14;
    localparam int unsigned PREFIX_CNT_W       = $clog2(MAX_PREFIX_DEFAULT + 1);

    localparam logic [2:0] index_reg_seg__ES = 3'd0;
    localparam logic [2:0] index_reg_seg__CS = 3'd1;
    localparam logic [2:0] index_reg_seg__SS = 3'd2;
    localparam logic [2:0] index_reg_seg__DS = 3'd3;
    localparam logic [2:0] index_reg_seg__FS = 3'd4;
    localparam logic [2:0] index_reg_seg__GS = 3'd5;

    localparam logic [0:0] STATE_COLLECT = 1'b0;
    localparam logic [0:0] STATE_HOLD    = 1'b1;

    typedef struct packed {
        logic                    lock;
        logic                    rep;
        logic                    repne;
        logic                    seg_override_valid;
        logic [2:0]              seg_override_index;
        logic                    operand_size;
        logic                    address_size;
        logic [PREFIX_CNT_W-1:0] count;
        logic                    fault_length;
    } prefix_record_t;

endpackage

// File: rtl/prefix_accumulator_decode_prefix.sv
// Combinational classifier for a single x86 prefix byte.
module decode_prefix
    import prefix_accumulator_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_present,
    output logic       o_lock,
    output logic       o_rep,
    output logic       o_repne,
    output logic       o_seg_valid,
    output logic [2:0] o_seg_index,
    output logic       o_operand_size,
    output logic       o_address_size
);

    always_comb begin
        o_lock         = 1'b0;
        o_rep          = 1'b0;
        o_repne        = 1'b0;
        o_seg_valid    = 1'b0;
        o_seg_index    = '0;
        o_operand_size = 1'b0;
        o_address_size = 1'b0;
        unique case (i_byte)
            8'hF0: o_lock = 1'b1;
            8'hF2: o_repne = 1'b1;
            8'hF3: o_rep = 1'b1;
            8'h26: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__ES; end
            8'h2E: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__CS; end
            8'h36: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__SS; end
            8'h3E: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__DS; end
            8'h64: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__FS; end
            8'h65: begin o_seg_valid = 1'b1; o_seg_index = index_reg_seg__GS; end
            8'h66: o_operand_size = 1'b1;
            8'h67: o_address_size = 1'b1;
            default: ;
        endcase
        o_is_present = o_lock | o_rep | o_repne | o_seg_valid
                     | o_operand_size | o_address_size;
    end

endmodule

// File: rtl/prefix_accumulator.sv
// Merges a run of x86 prefix bytes into one record and presents it together
// with the first non-prefix (opcode) byte over a valid/ready handshake.
module prefix_accumulator
    import prefix_accumulator_pkg::*;
#(
    parameter int unsigned MAX_PREFIX = MAX_PREFIX_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(MAX_PREFIX + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_opcode,
    output logic             o_lock,
    output logic             o_rep,
    output logic             o_repne,
    output logic             o_seg_override_valid,
    output logic [2:0]       o_seg_override_index,
    output logic             o_operand_size,
    output logic             o_address_size,
    output logic [CNT_W-1:0] o_prefix_count,
    output logic             o_fault_length
);

    logic [0:0]     state;
    prefix_record_t acc;
    prefix_record_t acc_next;
    prefix_record_t fault_record;
    prefix_record_t out_rec;
    logic [7:0]     out_opcode;
    logic           out_valid;

    logic           dec_is_present;
    logic           dec_lock;
    logic           dec_rep;
    logic           dec_repne;
    logic           dec_seg_valid;
    logic [2:0]     dec_seg_index;
    logic           dec_operand_size;
    logic           dec_address_size;

    logic           byte_accept;
    logic           at_limit;

    decode_prefix u_decode_prefix (
        .i_byte         (i_byte),
        .o_is_present   (dec_is_present),
        .o_lock         (dec_lock),
        .o_rep          (dec_rep),
        .o_repne        (dec_repne),
        .o_seg_valid    (dec_seg_valid),
        .o_seg_index    (dec_seg_index),
        .o_operand_size (dec_operand_size),
        .o_address_size (dec_address_size)
    );

    assign o_byte_ready = !i_flush & ((state == STATE_COLLECT) | i_ready);
    assign byte_accept  = i_byte_valid & o_byte_ready;
    assign at_limit     = (acc.count == PREFIX_CNT_W'(MAX_PREFIX));

    always_comb begin
        acc_next              = acc;
        acc_next.lock         = acc.lock | dec_lock;
        acc_next.operand_size = acc.operand_size | dec_operand_size;
        acc_next.address_size = acc.address_size | dec_address_size;
        acc_next.count        = acc.count + 1'b1;
        if (dec_seg_valid) begin
            acc_next.seg_override_valid = 1'b1;
            acc_next.seg_override_index = dec_seg_index;
        end
        if (dec_repne) begin
            acc_next.repne = 1'b1;
            acc_next.rep   = 1'b0;
        end else if (dec_rep) begin
            acc_next.rep   = 1'b1;
            acc_next.repne = 1'b0;
        end
    end

    always_comb begin
        fault_record              = acc;
        fault_record.fault_length = 1'b1;
    end

    // Accumulators are cleared as soon as a record is latched, so a byte
    // accepted during the HOLD handshake already sees a clean slate.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STATE_COLLECT;
            acc        <= '0;
            out_rec    <= '0;
            out_opcode <= '0;
            out_valid  <= 1'b0;
        end else if (i_flush) begin
            state      <= STATE_COLLECT;
            acc        <= '0;
            out_rec    <= '0;
            out_opcode <= '0;
            out_valid  <= 1'b0;
        end else begin
            if ((state == STATE_HOLD) && i_ready) begin
                out_valid <= 1'b0;
                state     <= STATE_COLLECT;
            end
            if (byte_accept) begin
                if (dec_is_present && !at_limit) begin
                    acc <= acc_next;
                end else begin
                    out_rec    <= dec_is_present ? fault_record : acc;
                    out_opcode <= i_byte;
                    out_valid  <= 1'b1;
                    state      <= STATE_HOLD;
                    acc        <= '0;
                end
            end
        end
    end

    assign o_valid              = out_valid;
    assign o_opcode             = out_opcode;
    assign o_lock               = out_rec.lock;
    assign o_rep                = out_rec.rep;
    assign o_repne              = out_rec.repne;
    assign o_seg_override_valid = out_rec.seg_override_valid;
    assign o_seg_override_index = out_rec.seg_override_index;
    assign o_operand_size       = out_rec.operand_size;
    assign o_address_size       = out_rec.address_size;
    assign o_prefix_count       = CNT_W'(out_rec.count);
    assign o_fault_length       = out_rec.fault_length;

endmodule

// File: tb/tb_prefix_accumulator.sv
// Directed self-checking bench for prefix_accumulator.
module tb_prefix_accumulator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_flush = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_valid = 1'b0;
    logic       o_byte_ready;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [7:0] o_opcode;
    logic       o_lock;
    logic       o_rep;
    logic       o_repne;
    logic       o_seg_override_valid;
    logic [2:0] o_seg_override_index;
    logic       o_operand_size;
    logic       o_address_size;
    logic [3:0] o_prefix_count;
    logic       o_fault_length;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    prefix_accumulator #(.MAX_PREFIX(14), .CNT_W(4)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .i_flush              (i_flush),
        .i_byte               (i_byte),
        .i_byte_valid         (i_byte_valid),
        .o_byte_ready         (o_byte_ready),
        .o_valid              (o_valid),
        .i_ready              (i_ready),
        .o_opcode             (o_opcode),
        .o_lock               (o_lock),
        .o_rep                (o_rep),
        .o_repne              (o_repne),
        .o_seg_override_valid (o_seg_override_valid),
        .o_seg_override_index (o_seg_override_index),
        .o_operand_size       (o_operand_size),
        .o_address_size       (o_address_size),
        .o_prefix_count       (o_prefix_count),
        .o_fault_length       (o_fault_length)
    );

    task automatic drive_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clock);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_opcode !== 8'h00) begin n_fail++; $display("FAIL reset_opcode: got %h want 00", o_opcode); end
        n_checks++; if (o_prefix_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_prefix_count); end
        n_checks++; if ({o_lock, o_rep, o_repne, o_seg_override_valid, o_operand_size, o_address_size, o_fault_length} !== 7'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 0000000", {o_lock, o_rep, o_repne, o_seg_override_valid, o_operand_size, o_address_size, o_fault_length}); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (o_byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_byte_ready); end
        idle_cycle();
    endtask

    task automatic test_two_prefixes();
        i_ready = 1'b1;
        drive_byte(8'h66);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL two_pfx_early_valid: got %b want 0", o_valid); end
        drive_byte(8'h2E);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL two_pfx_mid_valid: got %b want 0", o_valid); end
        drive_byte(8'h8B);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL two_pfx_valid: got %b want 1", o_valid); end
        n_checks++; if (o_opcode !== 8'h8B) begin n_fail++; $display("FAIL two_pfx_opcode: got %h want 8b", o_opcode); end
        n_checks++; if (o_operand_size !== 1'b1) begin n_fail++; $display("FAIL two_pfx_opsize: got %b want 1", o_operand_size); end
        n_checks++; if (o_seg_override_valid !== 1'b1) begin n_fail++; $display("FAIL two_pfx_seg_valid: got %b want 1", o_seg_override_valid); end
        n_checks++; if (o_seg_override_index !== 3'd1) begin n_fail++; $display("FAIL two_pfx_seg_index: got %0d want 1", o_seg_override_index); end
        n_checks++; if (o_prefix_count !== 4'd2) begin n_fail++; $display("FAIL two_pfx_count: got %0d want 2", o_prefix_count); end
        n_checks++; if ({o_lock, o_rep, o_repne, o_address_size, o_fault_length} !== 5'b0)
            begin n_fail++; $display("FAIL two_pfx_other: got %b want 00000", {o_lock, o_rep, o_repne, o_address_size, o_fault_length}); end
        idle_cycle();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL two_pfx_consumed: got %b want 0", o_valid); end
    endtask

    task automatic test_rep_order();
        i_ready = 1'b1;
        drive_byte(8'hF3);
        drive_byte(8'hF2);
        drive_byte(8'hA4);
        n_checks++; if ({o_valid, o_repne, o_rep} !== 3'b110) begin n_fail++; $display("FAIL rep_f3f2: got valid/repne/rep %b want 110", {o_valid, o_repne, o_rep}); end
        n_checks++; if (o_prefix_count !== 4'd2) begin n_fail++; $display("FAIL rep_f3f2_count: got %0d want 2", o_prefix_count); end
        idle_cycle();
        drive_byte(8'hF2);
        drive_byte(8'hF3);
        drive_byte(8'hA4);
        n_checks++; if ({o_valid, o_repne, o_rep} !== 3'b101) begin n_fail++; $display("FAIL rep_f2f3: got valid/repne/rep %b want 101", {o_valid, o_repne, o_rep}); end
        n_checks++; if (o_opcode !== 8'hA4) begin n_fail++; $display("FAIL rep_f2f3_opcode: got %h want a4", o_opcode); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        i_ready      = 1'b0;
        i_byte       = 8'h90;
        i_byte_valid = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b want 0", c, o_byte_ready); end
            n_checks++; if ({o_valid, o_opcode, o_prefix_count} !== {1'b1, 8'h90, 4'd0})
                begin n_fail++; $display("FAIL bp_hold cycle %0d: got valid %b opcode %h count %0d want 1 90 0", c, o_valid, o_opcode, o_prefix_count); end
            @(posedge clock);
            #1;
        end
        i_ready = 1'b1;
        #1;
        n_checks++; if (o_byte_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %b want 1", o_byte_ready); end
        @(posedge clock);
        #1;
        i_byte_valid = 1'b0;
        n_checks++; if ({o_valid, o_opcode, o_prefix_count} !== {1'b1, 8'h90, 4'd0})
            begin n_fail++; $display("FAIL b2b_second: got valid %b opcode %h count %0d want 1 90 0", o_valid, o_opcode, o_prefix_count); end
        idle_cycle();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_length_fault();
        i_ready = 1'b0;
        for (int k = 0; k < 14; k++) drive_byte(8'h66);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL len_pre_valid: got %b want 0", o_valid); end
        drive_byte(8'h66);
        n_checks++; if ({o_valid, o_fault_length} !== 2'b11) begin n_fail++; $display("FAIL len_fault: got valid/fault %b want 11", {o_valid, o_fault_length}); end
        n_checks++; if (o_opcode !== 8'h66) begin n_fail++; $display("FAIL len_opcode: got %h want 66", o_opcode); end
        n_checks++; if (o_prefix_count !== 4'd14) begin n_fail++; $display("FAIL len_count: got %0d want 14", o_prefix_count); end
        n_checks++; if (o_operand_size !== 1'b1) begin n_fail++; $display("FAIL len_opsize: got %b want 1", o_operand_size); end
        i_ready = 1'b1;
        idle_cycle();
        drive_byte(8'h90);
        n_checks++; if ({o_valid, o_fault_length, o_operand_size, o_prefix_count} !== {3'b100, 4'd0})
            begin n_fail++; $display("FAIL len_recover: got valid/fault/opsize %b count %0d want 100 0", {o_valid, o_fault_length, o_operand_size}, o_prefix_count); end
        idle_cycle();
    endtask

    task automatic test_flush();
        i_ready = 1'b1;
        drive_byte(8'h67);
        drive_byte(8'h26);
        i_flush      = 1'b1;
        i_byte       = 8'hC3;
        i_byte_valid = 1'b1;
        #1;
        n_checks++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", o_byte_ready); end
        @(posedge clock);
        #1;
        i_flush      = 1'b0;
        i_byte_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", o_valid); end
        drive_byte(8'hC3);
        n_checks++; if ({o_valid, o_opcode} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL flush_next: got valid %b opcode %h want 1 c3", o_valid, o_opcode); end
        n_checks++; if ({o_prefix_count, o_address_size, o_seg_override_valid} !== 6'b0)
            begin n_fail++; $display("FAIL flush_cleared: got count %0d addr %b seg %b want 0 0 0", o_prefix_count, o_address_size, o_seg_override_valid); end
        idle_cycle();
        i_ready = 1'b0;
        drive_byte(8'h90);
        i_flush = 1'b1;
        i_ready = 1'b1;
        @(posedge clock);
        #1;
        i_flush = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", o_valid); end
    endtask

    task automatic test_reset_mid_run();
        i_ready = 1'b0;
        drive_byte(8'hF0);
        drive_byte(8'h90);
        n_checks++; if ({o_valid, o_lock} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got valid/lock %b want 11", {o_valid, o_lock}); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({o_valid, o_lock, o_opcode} !== 10'b0) begin n_fail++; $display("FAIL mid_async: got valid %b lock %b opcode %h want 0 0 00", o_valid, o_lock, o_opcode); end
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        n_checks++; if (o_byte_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", o_byte_ready); end
        i_ready = 1'b1;
        drive_byte(8'h65);
        drive_byte(8'h8B);
        n_checks++; if ({o_valid, o_opcode, o_lock} !== {1'b1, 8'h8B, 1'b0})
            begin n_fail++; $display("FAIL mid_fresh: got valid %b opcode %h lock %b want 1 8b 0", o_valid, o_opcode, o_lock); end
        n_checks++; if ({o_seg_override_valid, o_seg_override_index, o_prefix_count} !== {1'b1, 3'd5, 4'd1})
            begin n_fail++; $display("FAIL mid_fresh_seg: got seg %b idx %0d count %0d want 1 5 1", o_seg_override_valid, o_seg_override_index, o_prefix_count); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_two_prefixes();
        test_rep_order();
        test_back_to_back();
        test_length_fault();
        test_flush();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
